// File: rtl/event_timestamp_capture.sv
// Event timestamp capture: stamps trigger/tick events with a free-running counter,
// buffers them in a FIFO for the CPU and raises a threshold/overflow interrupt.
module event_timestamp_capture #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig_in,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;

  logic [31:0]            counter;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trig_prev;
  logic                   rise_q;
  logic                   fall_q;
  logic [7:0]             control;
  logic [31:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic [15:0]            hold_hi;
  logic [15:0]            cnt_hold;

  logic        trig_sync;
  logic        event_hit;
  logic        rd_en;
  logic        wr_en;
  logic        flush;
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_push;
  logic        ovf_set;
  logic [31:0] head;
  logic [4:0]  level5;
  logic [3:0]  threshold;
  logic        irq_cond;
  logic [15:0] rdata;

  assign trig_sync = sync_q[SYNC_STAGES-1];
  assign threshold = control[7:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
    end else begin
      counter <= counter + 32'd1;
    end
  end

  // Edge flags are registered so a change of edge_sel only picks between
  // already-qualified transitions and cannot itself produce an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      trig_prev <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], trig_in};
      trig_prev <= trig_sync;
      rise_q    <= trig_sync & ~trig_prev;
      fall_q    <= ~trig_sync & trig_prev;
    end
  end

  always_comb begin
    event_hit = 1'b0;
    if (control[1]) begin
      if (control[3]) event_hit = tick_in;
      else if (control[2]) event_hit = fall_q;
      else event_hit = rise_q;
    end
  end

  assign rd_en   = chipselect & ~read_n;
  assign wr_en   = chipselect & ~write_n;
  assign flush   = wr_en & (address == 3'd1) & writedata[15];
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign pop     = rd_en & (address == 3'd3) & ~empty & ~flush;
  assign do_push = event_hit & ~flush & (~full | pop);
  assign ovf_set = event_hit & ~flush & full & ~pop;
  assign head    = mem[rd_ptr];
  assign level5  = 5'(level);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= counter;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A same-cycle overflow beats the software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (wr_en && address == 3'd0) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control <= '0;
    end else if (wr_en && address == 3'd1) begin
      control <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_hi  <= '0;
      cnt_hold <= '0;
    end else if (rd_en) begin
      if (address == 3'd2) hold_hi <= empty ? 16'h0000 : head[31:16];
      if (address == 3'd4) cnt_hold <= counter[31:16];
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      3'd0: begin
        rdata[0]   = ~empty;
        rdata[1]   = overflow;
        rdata[2]   = full;
        rdata[8:4] = level5;
      end
      3'd1:    rdata = {8'h00, control};
      3'd2:    rdata = empty ? 16'h0000 : head[15:0];
      3'd3:    rdata = hold_hi;
      3'd4:    rdata = counter[15:0];
      3'd5:    rdata = cnt_hold;
      default: rdata = '0;
    endcase
  end

  assign irq_cond = control[0] &
                    (overflow | ((threshold != 4'd0) & (level5 >= {1'b0, threshold})));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (rd_en) readdata <= rdata;
      irq <= irq_cond;
    end
  end

endmodule

// File: tb/tb_event_timestamp_capture.sv
// Scoreboard bench for event_timestamp_capture: stimulus queues expected read
// data / irq levels, a monitor pops and compares them when the DUT presents them.
module tb_event_timestamp_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig_in = 1'b0;
  logic        tick_in = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  event_timestamp_capture #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .tick_in(tick_in),
    .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference counter: zero in reset, +1 on every edge afterwards.
  logic [31:0] mcnt;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) mcnt <= '0;
    else          mcnt <= mcnt + 32'd1;

  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t e;
  logic rd_pend = 1'b0;
  logic irq_req = 1'b0;

  always @(posedge clk) rd_pend <= chipselect & ~read_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: readdata=%h with nothing expected", readdata);
      end else begin
        e = rd_q.pop_front();
        if (readdata !== e.v) begin
          errors++;
          $display("FAIL %s: readdata=%h expected=%h", e.nm, readdata, e.v);
        end
      end
    end
    if (irq_req && irq_q.size() != 0) begin
      e = irq_q.pop_front();
      checks++;
      if (irq !== e.v[0]) begin
        errors++;
        $display("FAIL %s: irq=%b expected=%b", e.nm, irq, e.v[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] v, input string nm);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    rd_q.push_back('{nm, v});
    step();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic tick_pulse(output logic [31:0] ts);
    ts = mcnt;
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic expect_irq(input logic v, input string nm);
    irq_req = 1'b1;
    irq_q.push_back('{nm, {15'h0, v}});
    step();
    irq_req = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] v);
    int guard = 0;
    while (mcnt != v && guard < 200000) begin
      step();
      guard++;
    end
    checks++;
    if (mcnt != v) begin
      errors++;
      $display("FAIL wait_cnt: counter=%h target=%h", mcnt, v);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, n, ts, t0, tnew, ta, tb_, tc, tx;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    rd(3'd0, 16'h0000, "rst_status");
    rd(3'd1, 16'h0000, "rst_control");
    rd(3'd2, 16'h0000, "rst_ts_lo");
    rd(3'd3, 16'h0000, "rst_ts_hi");
    rd(3'd5, 16'h0000, "rst_cnt_hi");
    rd(3'd6, 16'h0000, "rst_addr6");
    rd(3'd7, 16'h0000, "rst_addr7");
    expect_irq(1'b0, "rst_irq");
    c = mcnt;
    rd(3'd4, c[15:0], "cnt_lo_a");
    rd(3'd5, c[31:16], "cnt_hi_a");
    repeat (5) step();
    c = mcnt;
    rd(3'd4, c[15:0], "cnt_lo_b");

    // Rising edge of trig_in, timestamp = N + SYNC_STAGES + 1
    wr(3'd1, 16'h0002);
    rd(3'd1, 16'h0002, "ctrl_readback");
    n = mcnt;
    trig_in = 1'b1;
    repeat (3) step();
    trig_in = 1'b0;
    repeat (8) step();
    ts = n + 32'd3;
    rd(3'd0, 16'h0011, "rise_status");
    rd(3'd2, ts[15:0], "rise_ts_lo");
    rd(3'd3, ts[31:16], "rise_ts_hi");
    rd(3'd0, 16'h0000, "rise_drained");

    // Falling edge selection
    wr(3'd1, 16'h0006);
    repeat (4) step();
    rd(3'd0, 16'h0000, "edge_sel_no_spurious");
    trig_in = 1'b1;
    repeat (6) step();
    n = mcnt;
    trig_in = 1'b0;
    repeat (8) step();
    ts = n + 32'd3;
    rd(3'd0, 16'h0011, "fall_status");
    rd(3'd2, ts[15:0], "fall_ts_lo");
    rd(3'd3, ts[31:16], "fall_ts_hi");

    // tick_in source across the 16-bit boundary
    wr(3'd1, 16'h000A);
    wait_cnt(32'h0000FFFF);
    tick_pulse(tx);
    wait_cnt(32'h00010005);
    tick_pulse(tx);
    rd(3'd0, 16'h0021, "tick_status");
    rd(3'd2, 16'hFFFF, "tick1_lo");
    rd(3'd3, 16'h0000, "tick1_hi");
    rd(3'd2, 16'h0005, "tick2_lo");
    rd(3'd3, 16'h0001, "tick2_hi");
    rd(3'd2, 16'h0000, "ts_lo_empty");
    rd(3'd3, 16'h0000, "ts_hi_empty");
    rd(3'd0, 16'h0000, "level_after_empty_pop");

    // Fill past full: 17 events, 17th dropped with overflow
    t0 = mcnt;
    tick_in = 1'b1;
    repeat (17) step();
    tick_in = 1'b0;
    step();
    rd(3'd0, 16'h0107, "full_status");
    wr(3'd0, 16'h0000);
    rd(3'd0, 16'h0105, "ovf_cleared");

    // Push and pop together while full
    rd(3'd2, t0[15:0], "full_head_lo");
    tnew = mcnt;
    tick_in = 1'b1;
    rd(3'd3, t0[31:16], "full_head_hi");
    tick_in = 1'b0;
    step();
    rd(3'd0, 16'h0105, "full_push_pop_status");
    for (int i = 1; i < 16; i++) begin
      ts = t0 + 32'(i);
      rd(3'd2, ts[15:0], "drain_lo");
      rd(3'd3, ts[31:16], "drain_hi");
    end
    rd(3'd2, tnew[15:0], "newest_lo");
    rd(3'd3, tnew[31:16], "newest_hi");
    rd(3'd0, 16'h0000, "drained_status");

    // Capture disabled: threshold/irq only
    wr(3'd1, 16'h0031);
    tick_pulse(tx);
    step();
    rd(3'd0, 16'h0000, "capture_disabled");

    // Threshold interrupt
    wr(3'd1, 16'h003B);
    tick_pulse(ta);
    tick_pulse(tb_);
    tick_pulse(tc);
    expect_irq(1'b0, "irq_same_cycle_as_push");
    expect_irq(1'b1, "irq_threshold");
    rd(3'd0, 16'h0031, "thresh_status");
    rd(3'd2, ta[15:0], "thresh_pop_lo");
    rd(3'd3, ta[31:16], "thresh_pop_hi");
    step();
    expect_irq(1'b0, "irq_after_pop");

    // Flush coincident with an event
    tick_in = 1'b1;
    wr(3'd1, 16'h803B);
    tick_in = 1'b0;
    step();
    rd(3'd0, 16'h0000, "flush_status");
    rd(3'd1, 16'h003B, "ctrl_after_flush");
    expect_irq(1'b0, "irq_after_flush");

    repeat (3) step();
    checks++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: rd=%0d irq=%0d expected=0", rd_q.size(), irq_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
